// File: rtl/uart_frame_tx.sv
// uart_frame_tx: serializes one multi-byte sample word as back-to-back 8N1 characters on one line.
// Build option: define UART_FRAME_CHECKSUM_EN to append an XOR-of-payload checksum character.
module uart_frame_tx #(
  parameter int         CLK_FREQ    = 25000000,
  parameter int         BAUD        = 9600,
  parameter int         NUM_BYTES   = 2,
  parameter int         HEADER_EN   = 1,
  parameter logic [7:0] HEADER_BYTE = 8'hAA,
  parameter int         STOP_BITS   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_valid,
  input  logic [NUM_BYTES*8-1:0] frame_data,
  output logic                   frame_ready,
  output logic                   uart_tx,
  output logic                   busy,
  output logic                   frame_done
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW  = NUM_BYTES * 8;
  localparam int IW  = $clog2(NUM_BYTES + 2);
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int CSUM_EN = 1;
`else
  localparam int CSUM_EN = 0;
`endif
  localparam int NCHAR = NUM_BYTES + HEADER_EN + CSUM_EN;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NCHAR - 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(DIV - 2);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          baud_end;
  logic [7:0]    char_next;

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic [7:0] frame_xor;

  always_comb begin
    frame_xor = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      frame_xor = frame_xor ^ frame_data[i*8 +: 8];
    end
  end

  // The checksum occupies the final slot, after the payload buffer has drained.
  assign char_next = (byte_idx_q + IW'(1) == LAST_IDX) ? csum_q : buf_q[DW-1 -: 8];
`else
  assign char_next = buf_q[DW-1 -: 8];
`endif

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
`ifdef UART_FRAME_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d     = '0;
        bit_cnt_d  = '0;
        byte_idx_d = '0;
        if (frame_valid && ready_q) begin
          state_d = S_START;
          if (HEADER_EN != 0) begin
            shift_d = HEADER_BYTE;
            buf_d   = frame_data;
          end else begin
            shift_d = frame_data[DW-1 -: 8];
            buf_d   = frame_data << 8;
          end
`ifdef UART_FRAME_CHECKSUM_EN
          csum_d = frame_xor;
`endif
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_cnt_q != LAST_STOP) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (byte_idx_q != LAST_IDX) begin
            bit_cnt_d  = '0;
            byte_idx_d = byte_idx_q + IW'(1);
            shift_d    = char_next;
            buf_d      = buf_q << 8;
            state_d    = S_START;
          end else begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line is registered from the current state, so it trails the FSM by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[bit_cnt_q];
      default: tx_d = 1'b1;
    endcase
  end

  assign ready_d = (state_d == S_IDLE);
  assign done_d  = (state_q == S_STOP) && (bit_cnt_q == LAST_STOP) &&
                   (byte_idx_q == LAST_IDX) && (baud_q == BAUD_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign frame_ready = ready_q;
  assign uart_tx     = tx_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: three instances (header/2 bytes, 1 byte/2 stop bits, header/3 bytes),
// a serial-line receiver per instance, and expected characters queued at each accepted frame.
`timescale 1ns/1ps
module tb_uart_frame_tx;
  localparam int DIV = 10;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic [15:0] data_a = '0;
  logic [7:0]  data_b = '0;
  logic [23:0] data_c = '0;
  logic        ready_a, tx_a, busy_a, done_a;
  logic        ready_b, tx_b, busy_b, done_b;
  logic        ready_c, tx_c, busy_c, done_c;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rst_epoch = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_frame_tx #(.CLK_FREQ(1000), .BAUD(100), .NUM_BYTES(2), .HEADER_EN(1),
                  .HEADER_BYTE(8'hAA), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_valid(valid_a), .frame_data(data_a),
    .frame_ready(ready_a), .uart_tx(tx_a), .busy(busy_a), .frame_done(done_a));

  uart_frame_tx #(.CLK_FREQ(1000), .BAUD(100), .NUM_BYTES(1), .HEADER_EN(0),
                  .HEADER_BYTE(8'hAA), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_valid(valid_b), .frame_data(data_b),
    .frame_ready(ready_b), .uart_tx(tx_b), .busy(busy_b), .frame_done(done_b));

  uart_frame_tx #(.CLK_FREQ(1000), .BAUD(100), .NUM_BYTES(3), .HEADER_EN(1),
                  .HEADER_BYTE(8'hAA), .STOP_BITS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .frame_valid(valid_c), .frame_data(data_c),
    .frame_ready(ready_c), .uart_tx(tx_c), .busy(busy_c), .frame_done(done_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic tx_of(input int k);
    case (k)
      0: return tx_a;
      1: return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic rdy_of(input int k);
    case (k)
      0: return ready_a;
      1: return ready_b;
      default: return ready_c;
    endcase
  endfunction

  function automatic logic bsy_of(input int k);
    case (k)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic dn_of(input int k);
    case (k)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic int nstop(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  // Frame length in cycles: characters * (start + 8 data + stop bits) * DIV.
  function automatic int flen(input int k);
    case (k)
      0: return (3 + CS) * 10 * DIV;
      1: return (1 + CS) * 11 * DIV;
      default: return (4 + CS) * 10 * DIV;
    endcase
  endfunction

  task automatic drive(input int k, input logic v, input logic [23:0] d);
    case (k)
      0: begin valid_a = v; data_a = d[15:0]; end
      1: begin valid_b = v; data_b = d[7:0]; end
      default: begin valid_c = v; data_c = d; end
    endcase
  endtask

  task automatic push_exp(input int k, input logic [23:0] d);
    logic [7:0] cs;
    case (k)
      0: begin
        q0.push_back(8'hAA); q0.push_back(d[15:8]); q0.push_back(d[7:0]);
        cs = d[15:8] ^ d[7:0];
        if (CS != 0) q0.push_back(cs);
      end
      1: begin
        q1.push_back(d[7:0]);
        cs = d[7:0];
        if (CS != 0) q1.push_back(cs);
      end
      default: begin
        q2.push_back(8'hAA); q2.push_back(d[23:16]); q2.push_back(d[15:8]); q2.push_back(d[7:0]);
        cs = d[23:16] ^ d[15:8] ^ d[7:0];
        if (CS != 0) q2.push_back(cs);
      end
    endcase
  endtask

  // Receiver: samples each bit at its midpoint, so any drift in bit timing corrupts the character.
  task automatic rx_mon(input int k);
    logic [7:0] ch;
    logic [7:0] ex;
    logic       ok;
    int         ep;
    int         qn;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_of(k) === 1'b0) begin
        ep = rst_epoch;
        ok = 1'b1;
        ch = '0;
        repeat (DIV / 2) @(negedge clk);
        if (tx_of(k) !== 1'b0) ok = 1'b0;
        for (int b = 0; b < 8; b++) begin
          repeat (DIV) @(negedge clk);
          ch[b] = tx_of(k);
        end
        for (int s = 0; s < nstop(k); s++) begin
          repeat (DIV) @(negedge clk);
          if (tx_of(k) !== 1'b1) ok = 1'b0;
        end
        if (ep == rst_epoch) begin
          check_eq($sformatf("framing%0d", k), ok, 1'b1);
          case (k)
            0: qn = q0.size();
            1: qn = q1.size();
            default: qn = q2.size();
          endcase
          check_eq($sformatf("char_expected%0d", k), (qn > 0), 1'b1);
          if (qn > 0) begin
            case (k)
              0: ex = q0.pop_front();
              1: ex = q1.pop_front();
              default: ex = q2.pop_front();
            endcase
            check_eq($sformatf("char%0d", k), ch, ex);
            $display("dut%0d rx char %h (expected %h)", k, ch, ex);
          end
        end
      end
    end
  endtask

  initial rx_mon(0);
  initial rx_mon(1);
  initial rx_mon(2);

  task automatic send_frame(input int k, input logic [23:0] d, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (rdy_of(k) !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", (n < 2000), 1'b1);
    drive(k, 1'b1, d);
    @(posedge clk);
    #1;
    acc = cyc;
    drive(k, 1'b0, d);
    push_exp(k, d);
    $display("dut%0d frame %h accepted at cyc %0d", k, d, acc);
    @(negedge clk);
    check_eq("ready_drop", rdy_of(k), 1'b0);
    check_eq("tx_hold", tx_of(k), 1'b1);
    check_eq("busy_set", bsy_of(k), 1'b1);
    @(negedge clk);
    check_eq("tx_fall", tx_of(k), 1'b0);
  endtask

  task automatic wait_done(input int k, input int acc);
    int n;
    int rdy_hi;
    int bsy_lo;
    n = 0; rdy_hi = 0; bsy_lo = 0;
    while (dn_of(k) !== 1'b1 && n < 4000) begin
      if (rdy_of(k) !== 1'b0) rdy_hi++;
      if (bsy_of(k) !== 1'b1) bsy_lo++;
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", (n < 4000), 1'b1);
    check_eq("done_cycle", cyc - acc + 1, flen(k));
    check_eq("ready_low_in_frame", rdy_hi, 0);
    check_eq("busy_high_in_frame", bsy_lo, 0);
    @(negedge clk);
    check_eq("done_pulse", dn_of(k), 1'b0);
    check_eq("ready_back", rdy_of(k), 1'b1);
    check_eq("busy_clear", bsy_of(k), 1'b0);
    check_eq("tx_idle", tx_of(k), 1'b1);
  endtask

  initial begin
    int acc;
    int acc2;
    logic [23:0] d;

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_tx", tx_a, 1'b1);
    check_eq("rst_ready", ready_a, 1'b1);
    check_eq("rst_busy", busy_a, 1'b0);
    check_eq("rst_done", done_a, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame: AA 12 34
    send_frame(0, 24'h001234, acc);
    wait_done(0, acc);

    // valid held high across two frames: back-to-back acceptance at minimum spacing
    drive(0, 1'b1, 24'h000001);
    @(posedge clk);
    #1;
    acc = cyc;
    push_exp(0, 24'h000001);
    drive(0, 1'b1, 24'h000002);
    $display("dut0 frame 0001 accepted at cyc %0d (valid held)", acc);
    wait_done(0, acc);
    @(posedge clk);
    #1;
    acc2 = cyc;
    push_exp(0, 24'h000002);
    drive(0, 1'b0, 24'h000000);
    $display("dut0 frame 0002 accepted at cyc %0d (valid held)", acc2);
    check_eq("frame_spacing", acc2 - acc, flen(0) + 1);
    wait_done(0, acc2);

    // Asynchronous reset 57 cycles into a frame
    send_frame(0, 24'h001234, acc);
    while (cyc < acc + 57) @(posedge clk);
    #3 rst_n = 1'b0;
    rst_epoch++;
    #1;
    check_eq("midrst_tx", tx_a, 1'b1);
    check_eq("midrst_busy", busy_a, 1'b0);
    check_eq("midrst_ready", ready_a, 1'b1);
    q0.delete();
    $display("dut0 reset asserted at cyc %0d", cyc);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check_eq("postrst_ready", ready_a, 1'b1);
    check_eq("postrst_tx", tx_a, 1'b1);
    send_frame(0, 24'h005A3C, acc);
    wait_done(0, acc);

    // Single byte, no header, two stop bits
    send_frame(1, 24'h000080, acc);
    wait_done(1, acc);

    // Three payload bytes with header (plus checksum 5A when enabled)
    send_frame(2, 24'hA50FF0, acc);
    wait_done(2, acc);

    // valid toggled with other data while busy must be ignored
    send_frame(0, 24'h000F0F, acc);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive(0, i[0], 24'($urandom));
    end
    drive(0, 1'b0, 24'h000000);
    wait_done(0, acc);

    // A few random patterns on each instance
    for (int i = 0; i < 3; i++) begin
      d = 24'($urandom);
      send_frame(i, d, acc);
      wait_done(i, acc);
    end

    repeat (40) @(negedge clk);
    check_eq("q0_drained", q0.size(), 0);
    check_eq("q1_drained", q1.size(), 0);
    check_eq("q2_drained", q2.size(), 0);
    check_eq("final_busy", busy_a | busy_b | busy_c, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Multi-byte UART frame transmitter for the sensor path.
- Accepts one NUM_BYTES-wide sample word per handshake, e.g. the SHT21 MS/LS result bytes from the IIC controller. Serializes it as back-to-back 8N1 characters on a single uart_tx line, with an optional header byte.
- Replaces chained single-byte UART transmitters that share one output line. Baud generation is internal.

Parameters:
- CLK_FREQ, 25000000: clk frequency in Hz.
- BAUD, 9600: line rate. Bit period DIV = CLK_FREQ/BAUD cycles, integer truncation. DIV must be >= 2.
- NUM_BYTES, 2: payload bytes per frame, range 1..16.
- HEADER_EN, 1: 1 = send HEADER_BYTE before the payload; 0 = payload only.
- HEADER_BYTE, 8'hAA: sync byte value.
- STOP_BITS, 1: stop bits per character, 1 or 2.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset. Asynchronous assert, active-low.
- frame_valid, in, 1: frame_data is valid.
- frame_data, in, NUM_BYTES*8: payload. Bits [NUM_BYTES*8-1 -: 8] form byte 0 and are sent first.
- frame_ready, out, 1: block can accept a frame.
- uart_tx, out, 1: serial line, idle high.
- busy, out, 1: a frame is in progress.
- frame_done, out, 1: one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset values: uart_tx=1, frame_ready=1, busy=0, frame_done=0. All counters and shift registers are 0. State is IDLE.
- Reset mid-frame aborts immediately. uart_tx returns high asynchronously. No partial character is completed.
- Handshake: a transfer occurs on a rising edge where frame_valid && frame_ready.
  - frame_data is latched into an internal buffer that edge. The source may change it afterwards.
  - frame_ready = (state==IDLE). It is registered and drops the cycle after acceptance.
  - frame_valid while not ready is ignored. The source must hold it until ready.
- States:
  - IDLE: line high. On accept, load the first character (header if HEADER_EN, else byte 0), go to START.
  - START: uart_tx=0 for DIV cycles, then DATA.
  - DATA: 8 bits, LSB first, each held DIV cycles. The bit counter counts 0..7; then go to STOP.
  - STOP: uart_tx=1 for STOP_BITS*DIV cycles.
    - If characters remain: load the next character and go to START. There is no idle gap between characters.
    - Otherwise: pulse frame_done and go to IDLE.
- Timing:
  - uart_tx falls on the first edge after the accepting edge.
  - The baud counter runs 0..DIV-1 and is reset to 0 at every state entry. There is no drift between characters.
  - Frame length L = C*(9+STOP_BITS)*DIV cycles, where C = NUM_BYTES + HEADER_EN (+1 with checksum).
  - frame_done is asserted in the last cycle of the final stop bit. frame_ready is high on the following cycle.
  - A new frame is accepted as soon as frame_ready is 1. The minimum spacing between start bits of consecutive frames is L+1 cycles.
- Character order: header, byte 0, byte 1, ... byte NUM_BYTES-1, then checksum if enabled.
- The byte index counter has width clog2(NUM_BYTES+2). It never wraps within a frame and is cleared in IDLE.
- busy = (state != IDLE).
- uart_tx is driven from a register, so it is glitch-free.

Optional Feature:
- Macro: UART_FRAME_CHECKSUM_EN.
- Defined: one checksum character is appended after the last payload byte. Its value is the XOR of all payload bytes; the header is excluded. The checksum is computed at latch time, so frame length grows by one character.
- Undefined: no checksum logic and no extra character.

Test Plan:
- CLK_FREQ=1000, BAUD=100 (DIV=10), NUM_BYTES=2, HEADER_EN=1, frame_data=16'h1234, one-cycle valid -> line carries 0xAA, 0x12, 0x34. Each bit is exactly 10 cycles. uart_tx falls 1 cycle after accept. frame_done comes 300 cycles after the first start edge. frame_ready=0 throughout.
- Same configuration, frame_valid held high continuously with data 16'h0001 then 16'h0002 -> exactly two frames. The second start bit begins 301 cycles after the first. No data loss, no extra frames.
- Reset asserted at cycle 57 of a frame -> uart_tx=1 and busy=0 immediately (asynchronous). After release, frame_ready=1 and the next frame is sent intact.
- HEADER_EN=0, NUM_BYTES=1, STOP_BITS=2, data 8'h80 -> one character: start, 0000_0001 on the line LSB first, then 20 high cycles. frame_done follows at cycle 110.
- UART_FRAME_CHECKSUM_EN defined, NUM_BYTES=3, data 24'hA5_0F_F0 -> characters 0xAA, 0xA5, 0x0F, 0xF0, 0x5A.
- frame_valid toggled while busy with different data -> ignored. The in-flight frame is unchanged, and the toggle produces no extra frame.
